// File: rtl/fifo_drain_arb.sv
// Round-robin drain engine: pops one non-empty lane FIFO at a time and presents
// the captured word, tagged with its lane, on a single valid/ready stream.
module fifo_drain_arb #(
   parameter int N_DTPS     = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int LANE_W     = 2,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_DTPS*FIFO_WIDTH-1:0] fifo_data,
   input  logic [N_DTPS-1:0]            fifo_empty,
   output logic [N_DTPS-1:0]            fifo_pop,
   output logic [FIFO_WIDTH-1:0]        m_data,
   output logic [LANE_W-1:0]            m_lane,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [CNT_W-1:0]             xfer_cnt,
   output logic [1:0]                   state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [LANE_W-1:0] rr, sel, pick, cand;
   logic              found;
   logic [FIFO_WIDTH-1:0] lane_word [N_DTPS];

   for (genvar k = 0; k < N_DTPS; k++) begin : g_unpack
      assign lane_word[k] = fifo_data[k*FIFO_WIDTH +: FIFO_WIDTH];
   end

   // Scan rr, rr+1, ... wrapping at N_DTPS-1; the first non-empty lane wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = rr;
      for (int i = 0; i < N_DTPS; i++) begin
         if (!found && !fifo_empty[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
         cand = (cand == LANE_W'(N_DTPS-1)) ? '0 : cand + LANE_W'(1);
      end
   end

   always_comb begin
      fifo_pop = '0;
      if (!rst && state_q == IDLE && found) fifo_pop[pick] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = FETCH;
         FETCH:   state_d = HOLD;
         HOLD:    if (m_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Output stream: a word transfers in any cycle where m_valid && m_ready;
   // once m_valid is high, m_data/m_lane/m_valid stay frozen until that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel      <= '0;
         rr       <= '0;
         m_data   <= '0;
         m_lane   <= '0;
         m_valid  <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: if (found) sel <= pick;
            FETCH: begin
               m_data  <= lane_word[sel];
               m_lane  <= sel;
               m_valid <= 1'b1;
            end
            HOLD: if (m_ready) begin
               m_valid  <= 1'b0;
               xfer_cnt <= xfer_cnt + CNT_W'(1);
               rr       <= (sel == LANE_W'(N_DTPS-1)) ? '0 : sel + LANE_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Bench for fifo_drain_arb: lane FIFO models with read latency 1, a round-robin
// reference model feeding an expected queue, and directed plus random phases.
module tb_fifo_drain_arb;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int LW = 2;
   localparam int CW = 4;
   localparam int EW = LW + W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N*W-1:0] fifo_data = '0;
   logic [N-1:0]  fifo_empty = '1;
   logic [N-1:0]  fifo_pop;
   logic [W-1:0]  m_data;
   logic [LW-1:0] m_lane;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [CW-1:0] xfer_cnt;
   logic [1:0]    state_dbg;

   always #5 clk = ~clk;

   fifo_drain_arb #(.N_DTPS(N), .FIFO_WIDTH(W), .LANE_W(LW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop), .m_data(m_data), .m_lane(m_lane), .m_valid(m_valid),
      .m_ready(m_ready), .xfer_cnt(xfer_cnt), .state_dbg(state_dbg)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rst_seen = 1'b0;

   logic [W-1:0]  lane_q [N][$];
   logic [W-1:0]  lane_word [N] = '{default: '0};
   logic [N-1:0]  pop_s = '0;
   logic [EW-1:0] exp_q [$];
   logic [EW-1:0] got_q [$];
   int            pop_cyc_q [$];
   logic [LW-1:0] model_rr = '0;
   logic [CW-1:0] cnt_model = '0;
   bit            inflight = 1'b0;
   bit            valid_prev = 1'b0;
   bit            hold_prev = 1'b0;
   logic [EW-1:0] held = '0;
   int            pop_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Lane FIFO models: a pop seen in cycle t presents the next word in t+1.
   always @(posedge clk) begin
      cyc++;
      rst_seen = rst;
      #1;
      for (int k = 0; k < N; k++) begin
         if (pop_s[k] && lane_q[k].size() > 0) lane_word[k] = lane_q[k].pop_front();
         fifo_empty[k] = (lane_q[k].size() == 0);
         fifo_data[k*W +: W] = lane_word[k];
      end
   end

   // Reference model and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin : monitor
      logic [N-1:0]  exp_pop;
      logic [EW-1:0] e;
      int best, pk, d;
      if (rst_seen) begin
         exp_q.delete();
         model_rr  = '0;
         cnt_model = '0;
         inflight  = 1'b0;
         chk("rst_valid", m_valid, 0);
         chk("rst_out", {m_lane, m_data}, 0);
         chk("rst_state", state_dbg, 0);
      end
      exp_pop = '0;
      best = N;
      pk = 0;
      if (!rst && !inflight) begin
         for (int k = 0; k < N; k++) begin
            d = (k - int'(model_rr) + N) % N;
            if (!fifo_empty[k] && d < best) begin
               best = d;
               pk = k;
            end
         end
      end
      if (best < N) exp_pop[pk] = 1'b1;
      chk("fifo_pop", fifo_pop, exp_pop);
      pop_s = fifo_pop;
      if (best < N) begin
         inflight = 1'b1;
         exp_q.push_back({LW'(pk), lane_q[pk][0]});
         pop_cyc = cyc;
         pop_cyc_q.push_back(cyc);
      end
      chk("xfer_cnt", xfer_cnt, cnt_model);
      if (!rst_seen && m_valid) begin
         if (!valid_prev) chk("latency", cyc - pop_cyc, 2);
         if (hold_prev) chk("hold_stable", {m_lane, m_data}, held);
         if (m_ready && !rst) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("m_data", m_data, e[W-1:0]);
               chk("m_lane", m_lane, e[EW-1:W]);
               model_rr = e[EW-1:W] + 2'd1;
            end
            got_q.push_back({m_lane, m_data});
            cnt_model++;
            inflight = 1'b0;
         end
      end
      valid_prev = m_valid && !rst_seen;
      hold_prev  = m_valid && !m_ready && !rst_seen;
      held       = {m_lane, m_data};
   end

   task automatic wait_got(input int n, input int budget);
      int t = 0;
      while (got_q.size() < n && t < budget) begin
         step(1);
         t++;
      end
      chk("wait_outputs", got_q.size(), n);
   endtask

   task automatic expect_got(input string tag, input int idx, input int lane, input int data);
      logic [EW-1:0] g;
      g = (idx < got_q.size()) ? got_q[idx] : '1;
      chk({tag, "_lane"}, g[EW-1:W], lane);
      chk({tag, "_data"}, g[W-1:0], data);
   endtask

   initial begin : stim
      int base, pc, t;
      logic [CW-1:0] cexp;
      int rr_lane [5] = '{0, 1, 2, 3, 0};

      // Reset with all lanes non-empty, then round-robin over all lanes.
      rst = 1'b1;
      m_ready = 1'b1;
      lane_q[0].push_back(16'h1000);
      lane_q[0].push_back(16'h1000);
      for (int k = 1; k < N; k++) lane_q[k].push_back(W'(16'h1000 + k));
      step(4);
      rst = 1'b0;
      @(negedge clk);
      chk("first_pop", fifo_pop, 4'b0001);
      wait_got(5, 60);
      for (int i = 0; i < 5; i++)
         expect_got($sformatf("rr%0d", i), i, rr_lane[i], 16'h1000 + rr_lane[i]);

      // Single non-empty lane, served every 3 cycles.
      base = got_q.size();
      pc = pop_cyc_q.size();
      cexp = cnt_model + CW'(2);
      lane_q[2].push_back(16'hA001);
      lane_q[2].push_back(16'hA002);
      wait_got(base + 2, 40);
      expect_got("single0", base, 2, 16'hA001);
      expect_got("single1", base + 1, 2, 16'hA002);
      chk("single_spacing", (pop_cyc_q.size() > pc + 1) ? pop_cyc_q[pc+1] - pop_cyc_q[pc] : 0, 3);
      step(1);
      chk("single_cnt", xfer_cnt, cexp);

      // Backpressure for 10 cycles; a lane filling meanwhile must not be popped.
      m_ready = 1'b0;
      base = got_q.size();
      lane_q[1].push_back(16'hB001);
      t = 0;
      while (!m_valid && t < 20) begin
         step(1);
         t++;
      end
      chk("bp_valid", m_valid, 1);
      cexp = cnt_model + CW'(1);
      lane_q[0].push_back(16'hB000);
      step(10);
      chk("bp_hold_data", {m_lane, m_data}, {2'd1, 16'hB001});
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      step(1);
      chk("bp_cnt", xfer_cnt, cexp);
      chk("bp_one", got_q.size(), base + 1);
      m_ready = 1'b1;
      wait_got(base + 2, 30);
      expect_got("bp0", base, 1, 16'hB001);
      expect_got("bp1", base + 1, 0, 16'hB000);

      // rr = 1, lanes 1 and 2 empty: lane 3 then lane 0.
      base = got_q.size();
      lane_q[0].push_back(16'hC000);
      lane_q[3].push_back(16'hC003);
      wait_got(base + 2, 30);
      expect_got("skip0", base, 3, 16'hC003);
      expect_got("skip1", base + 1, 0, 16'hC000);

      // Reset in the FETCH cycle: popped word discarded, rr back to 0.
      base = got_q.size();
      lane_q[2].push_back(16'hD002);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (fifo_pop == '0 && t < 20);
      chk("mid_pop", fifo_pop, 4'b0100);
      @(posedge clk);
      #2;
      rst = 1'b1;
      lane_q[0].push_back(16'hD000);
      lane_q[3].push_back(16'hD003);
      step(1);
      chk("mid_valid", m_valid, 0);
      chk("mid_cnt", xfer_cnt, 0);
      step(1);
      chk("mid_valid2", m_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_first_pop", fifo_pop, 4'b0001);
      wait_got(base + 2, 30);
      expect_got("mid0", base, 0, 16'hD000);
      expect_got("mid1", base + 1, 3, 16'hD003);

      // Random traffic and backpressure; the counter wraps several times.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0)
            lane_q[$urandom_range(0, N-1)].push_back(W'($urandom_range(0, 16'hFFFF)));
         m_ready = 1'($urandom_range(0, 1));
         step(1);
      end
      m_ready = 1'b1;
      t = 0;
      while (t < 3000 && (inflight || exp_q.size() != 0 || fifo_empty != '1 ||
             lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size() != 0)) begin
         step(1);
         t++;
      end
      chk("drain_expq", exp_q.size(), 0);
      chk("drain_lanes", fifo_empty, 4'b1111);
      step(3);
      chk("idle_valid", m_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
